// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-inverse datapath.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    MULT,
    UPDATE,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/divider.sv
// Restoring shift-subtract unsigned divider; start-to-valid latency is WIDTH+2 cycles.
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             valid_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_q, r_d, r_rem, r_quot, r_remo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_fin, r_valid;
  logic [WIDTH:0]   w_trial, w_sub;

  // rem < divisor always holds, so a non-negative difference fits in WIDTH bits
  assign w_trial = {r_rem, r_q[WIDTH-1]};
  assign w_sub   = w_trial - {1'b0, r_d};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_q     <= '0;
      r_d     <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_busy) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
          if (!w_sub[WIDTH]) begin
            r_rem <= w_sub[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          r_busy <= 1'b0;
          r_fin  <= 1'b1;
          r_quot <= r_q;
          r_remo <= r_rem;
        end
      end else if (r_fin) begin
        r_fin   <= 1'b0;
        r_valid <= 1'b1;
      end else if (ready_in) begin
        r_q    <= dividend_in;
        r_d    <= divisor_in;
        r_rem  <= '0;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end
    end
  end

  assign quotient_out  = r_quot;
  assign remainder_out = r_remo;
  assign busy_out      = r_busy;
  assign valid_out     = r_valid;

endmodule

// File: rtl/mod_inverse.sv
// Modular inverse via extended Euclid, tracking only the Bezout coefficient t.
//   state  | meaning
//   IDLE   | waiting for start
//   DIVIDE | divider running q = r0/r1
//   MULT   | shift-add q*t1, WIDTH cycles
//   UPDATE | rotate r and t pairs
//   FIX    | check gcd, normalise t0 into [0,m)
//   DONE   | publish result, valid next cycle
module mod_inverse
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             busy_out,
  output logic             valid_out,
  output logic             error_out
);
  localparam int TW = WIDTH + 2;
  localparam int PW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_m, r_r0, r_r1, r_rem, r_mplier, r_result, r_value;
  logic signed [TW-1:0] r_t0, r_t1, w_t0_fixed;
  logic signed [PW-1:0] r_mcand, r_prod, w_diff;
  logic [CW-1:0]        r_cnt;
  logic                 r_div_sent, r_err, r_valid, r_error;
  logic                 w_div_start, w_div_busy, w_div_valid, w_unused;
  logic [WIDTH-1:0]     w_quot, w_drem;

  divider #(.WIDTH(WIDTH)) u_div (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .ready_in      (w_div_start),
    .dividend_in   (r_r0),
    .divisor_in    (r_r1),
    .quotient_out  (w_quot),
    .remainder_out (w_drem),
    .busy_out      (w_div_busy),
    .valid_out     (w_div_valid)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // value 0 skips the divider: r1=0 goes straight to the gcd check, which fails
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (ready_in) begin
        if (modulus_in < WIDTH'(2)) w_next = DONE;
        else if (value_in == '0)    w_next = FIX;
        else                        w_next = DIVIDE;
      end
      DIVIDE:  if (w_div_valid) w_next = MULT;
      MULT:    if (r_cnt == '0) w_next = UPDATE;
      UPDATE:  w_next = (r_rem == '0) ? FIX : DIVIDE;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_out    = (r_state != IDLE) && (r_state != DONE);
    w_div_start = (r_state == DIVIDE) && !r_div_sent && !w_div_busy;
  end

  // |t| <= m keeps the truncated difference exact
  assign w_diff     = $signed({{WIDTH{r_t0[TW-1]}}, r_t0}) - r_prod;
  assign w_t0_fixed = r_t0[TW-1] ? (r_t0 + $signed({2'b00, r_m})) : r_t0;
  assign w_unused   = ^{w_diff[PW-1:TW], w_t0_fixed[TW-1:WIDTH]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_m        <= '0;
      r_r0       <= '0;
      r_r1       <= '0;
      r_rem      <= '0;
      r_mplier   <= '0;
      r_result   <= '0;
      r_value    <= '0;
      r_t0       <= '0;
      r_t1       <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_div_sent <= 1'b0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (ready_in) begin
          r_m      <= modulus_in;
          r_r0     <= modulus_in;
          r_r1     <= value_in;
          r_t0     <= '0;
          r_t1     <= TW'(1);
          r_err    <= (modulus_in < WIDTH'(2));
          r_result <= '0;
        end
        DIVIDE: begin
          if (w_div_start) r_div_sent <= 1'b1;
          if (w_div_valid) begin
            r_div_sent <= 1'b0;
            r_mplier   <= w_quot;
            r_rem      <= w_drem;
            r_mcand    <= $signed({{WIDTH{r_t1[TW-1]}}, r_t1});
            r_prod     <= '0;
            r_cnt      <= CW'(WIDTH - 1);
          end
        end
        MULT: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand <<< 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
        end
        UPDATE: begin
          r_r0 <= r_r1;
          r_r1 <= r_rem;
          r_t0 <= r_t1;
          r_t1 <= w_diff[TW-1:0];
        end
        FIX: begin
          if (r_r0 != WIDTH'(1)) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else begin
            r_result <= w_t0_fixed[WIDTH-1:0];
          end
        end
        DONE: begin
          r_valid <= 1'b1;
          r_value <= r_result;
          r_error <= r_err;
        end
        default: ;
      endcase
    end
  end

  assign value_out = r_value;
  assign valid_out = r_valid;
  assign error_out = r_error;

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse against a brute-force modular-inverse model.
module tb_mod_inverse;
  localparam int W       = 16;
  localparam int LAT_MAX = 2*W*(2*W+4) + 4;
  localparam int TMO     = 2000;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         ready_in = 1'b0;
  logic [W-1:0] value_in = '0;
  logic [W-1:0] modulus_in = '0;
  logic [W-1:0] value_out;
  logic         busy_out, valid_out, error_out;

  int total = 0;
  int bad   = 0;

  mod_inverse #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (ready_in),
    .value_in   (value_in),
    .modulus_in (modulus_in),
    .value_out  (value_out),
    .busy_out   (busy_out),
    .valid_out  (valid_out),
    .error_out  (error_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference: exhaustive search for x in [0,m) with v*x mod m == 1; -1 if none.
  function automatic int ref_inv(input longint v, input longint m);
    if (m < 2) return -1;
    for (longint x = 0; x < m; x++)
      if ((v * x) % m == 1) return int'(x);
    return -1;
  endfunction

  // Issue one start, scramble inputs afterwards, wait (bounded) for valid_out.
  task automatic do_op(input logic [W-1:0] v, input logic [W-1:0] m,
                       output logic [W-1:0] rv, output logic re,
                       output int lat, output logic bsy1);
    @(posedge clk_in); #1;
    value_in = v; modulus_in = m; ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    value_in = W'($urandom); modulus_in = W'($urandom);
    bsy1 = busy_out;
    lat = 1;
    while (valid_out !== 1'b1 && lat < TMO) begin
      @(posedge clk_in); #1;
      lat++;
    end
    rv = value_out;
    re = error_out;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    total++; if (value_out !== '0) begin bad++; $display("FAIL reset_value got=%0d want=0", value_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    total++; if (error_out !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_known();
    logic [W-1:0] tv [4] = '{16'd17, 16'd3, 16'd20, 16'd1};
    logic [W-1:0] tm [4] = '{16'd3120, 16'd7, 16'd7, 16'd2};
    logic [W-1:0] te [4] = '{16'd2753, 16'd5, 16'd6, 16'd1};
    logic [W-1:0] rv;
    logic re, b1;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(tv[i], tm[i], rv, re, lat, b1);
      total++; if (lat >= TMO || lat > LAT_MAX) begin bad++; $display("FAIL known_latency v=%0d m=%0d got=%0d want<=%0d", tv[i], tm[i], lat, LAT_MAX); end
      total++; if (rv !== te[i]) begin bad++; $display("FAIL known_value v=%0d m=%0d got=%0d want=%0d", tv[i], tm[i], rv, te[i]); end
      total++; if (re !== 1'b0) begin bad++; $display("FAIL known_error v=%0d m=%0d got=%b want=0", tv[i], tm[i], re); end
      total++; if (b1 !== 1'b1) begin bad++; $display("FAIL known_busy v=%0d m=%0d got=%b want=1", tv[i], tm[i], b1); end
      @(posedge clk_in); #1;
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL known_valid_pulse got=%b want=0", valid_out); end
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] tv [5] = '{16'd6, 16'd0, 16'd7, 16'd5, 16'd9};
    logic [W-1:0] tm [5] = '{16'd9, 16'd11, 16'd7, 16'd1, 16'd0};
    logic [W-1:0] rv;
    logic re, b1;
    int lat, lmax;
    for (int i = 0; i < 5; i++) begin
      do_op(tv[i], tm[i], rv, re, lat, b1);
      lmax = (tm[i] < 2) ? 3 : LAT_MAX;
      total++; if (lat >= TMO || lat > lmax) begin bad++; $display("FAIL err_latency v=%0d m=%0d got=%0d want<=%0d", tv[i], tm[i], lat, lmax); end
      total++; if (re !== 1'b1) begin bad++; $display("FAIL err_flag v=%0d m=%0d got=%b want=1", tv[i], tm[i], re); end
      total++; if (rv !== '0) begin bad++; $display("FAIL err_value v=%0d m=%0d got=%0d want=0", tv[i], tm[i], rv); end
    end
    repeat (5) @(posedge clk_in);
    #1;
    total++; if (error_out !== 1'b1) begin bad++; $display("FAIL err_hold got=%b want=1", error_out); end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int waited = 0;
    logic [W-1:0] rv;
    logic re;
    @(posedge clk_in); #1;
    value_in = 16'd17; modulus_in = 16'd3120; ready_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_in); #1;
      if (valid_out === 1'b1) nvalid++;
      value_in = W'($urandom); modulus_in = W'($urandom);
    end
    ready_in = 1'b0;
    while (valid_out !== 1'b1 && waited < TMO) begin
      @(posedge clk_in); #1;
      waited++;
    end
    total++; if (waited >= TMO) begin bad++; $display("FAIL b2b_timeout got=%0d want<%0d", waited, TMO); end
    rv = value_out;
    re = error_out;
    for (int i = 0; i < 60; i++) begin
      if (valid_out === 1'b1) nvalid++;
      @(posedge clk_in); #1;
    end
    total++; if (nvalid != 1) begin bad++; $display("FAIL b2b_count got=%0d want=1", nvalid); end
    total++; if (rv !== 16'd2753) begin bad++; $display("FAIL b2b_value got=%0d want=2753", rv); end
    total++; if (re !== 1'b0) begin bad++; $display("FAIL b2b_error got=%b want=0", re); end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    logic [W-1:0] rv;
    logic re, b1;
    int lat;
    @(posedge clk_in); #1;
    value_in = 16'd17; modulus_in = 16'd3120; ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    // first divide occupies W+3 cycles, so this lands inside the first multiply
    repeat (24) @(posedge clk_in);
    #1;
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy_out); end
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    total++; if (value_out !== '0) begin bad++; $display("FAIL rmid_value got=%0d want=0", value_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy_out); end
    total++; if (error_out !== 1'b0) begin bad++; $display("FAIL rmid_error got=%b want=0", error_out); end
    for (int i = 0; i < 300; i++) begin
      if (valid_out === 1'b1) nvalid++;
      @(posedge clk_in); #1;
    end
    total++; if (nvalid != 0) begin bad++; $display("FAIL rmid_no_valid got=%0d want=0", nvalid); end
    do_op(16'd3, 16'd7, rv, re, lat, b1);
    total++; if (lat >= TMO || rv !== 16'd5 || re !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0d err=%b lat=%0d want=5 err=0", rv, re, lat); end
  endtask

  task automatic test_random();
    logic [W-1:0] v, m, rv;
    logic re, b1;
    int lat, exp_inv, tries;
    longint prod;
    for (int n = 0; n < 16; n++) begin
      tries = 0;
      do begin
        m = W'($urandom_range(65535, 2));
        v = W'($urandom);
        exp_inv = ref_inv(longint'(v), longint'(m));
        tries++;
      end while (exp_inv < 0 && tries < 50);
      if (exp_inv < 0) begin m = 16'd7; v = 16'd3; exp_inv = 5; end
      do_op(v, m, rv, re, lat, b1);
      prod = (longint'(v) * longint'(rv)) % longint'(m);
      total++; if (lat >= TMO || lat > LAT_MAX) begin bad++; $display("FAIL rand_latency v=%0d m=%0d got=%0d want<=%0d", v, m, lat, LAT_MAX); end
      total++; if (re !== 1'b0) begin bad++; $display("FAIL rand_error v=%0d m=%0d got=%b want=0", v, m, re); end
      total++; if (int'(rv) != exp_inv) begin bad++; $display("FAIL rand_value v=%0d m=%0d got=%0d want=%0d", v, m, rv, exp_inv); end
      total++; if (prod != 1) begin bad++; $display("FAIL rand_product v=%0d m=%0d got=%0d want=1", v, m, prod); end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
